// File: rtl/orb_wr_arbiter.sv
// Write-port arbiter for the ping-pong orbital frame RAMs: per-requester FIFOs drained
// round-robin, one word per clock, into the bank not currently being read.
module orb_wr_arbiter #(
  parameter int N_REQ      = 5,
  parameter int AW         = 11,
  parameter int DW         = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic                wren1,
  output logic                wren2,
  output logic [2:0]          grant_id,
  output logic [N_REQ-1:0]    ovf,
  input  logic                ovf_clr,
  output logic                busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 1 + AW + DW;

  logic [EW-1:0]      mem_q    [N_REQ][FIFO_DEPTH];
  logic [EW-1:0]      mem_d    [N_REQ][FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr_q [N_REQ];
  logic [PW-1:0]      rd_ptr_d [N_REQ];
  logic [PW-1:0]      wr_ptr_q [N_REQ];
  logic [PW-1:0]      wr_ptr_d [N_REQ];
  logic [CW-1:0]      cnt_q    [N_REQ];
  logic [CW-1:0]      cnt_d    [N_REQ];

  logic [2:0]         rr_q, rr_d;
  logic [N_REQ-1:0]   ovf_q, ovf_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [DW-1:0]      wr_data_q, wr_data_d;
  logic               wren1_q, wren1_d;
  logic               wren2_q, wren2_d;
  logic [2:0]         grant_id_q, grant_id_d;

  logic [N_REQ-1:0]   nonempty;
  logic [N_REQ-1:0]   pop;
  logic [N_REQ-1:0]   push;
  logic               found;
  logic [2:0]         gnt;
  logic [EW-1:0]      head;

  // Round-robin search: first pass from the pointer upward, second pass wraps to 0.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && (i >= int'(rr_q)) && nonempty[i]) begin
        found = 1'b1;
        gnt   = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && nonempty[i]) begin
        found = 1'b1;
        gnt   = 3'(i);
      end
    end
  end

  always_comb begin
    head  = '0;
    mem_d = mem_q;
    for (int i = 0; i < N_REQ; i++) begin
      pop[i] = found && (gnt == 3'(i));
      if (pop[i]) head = mem_q[i][rd_ptr_q[i]];
      // A full FIFO still accepts a word when its head leaves on the same edge.
      push[i]     = req_we[i] && ((cnt_q[i] != CW'(FIFO_DEPTH)) || pop[i]);
      ovf_d[i]    = (req_we[i] && !push[i]) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = {sw, req_addr[i*AW +: AW], req_data[i*DW +: DW]};
      end
    end
  end

  always_comb begin
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wren1_d    = 1'b0;
    wren2_d    = 1'b0;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
    if (found) begin
      wr_addr_d  = head[DW +: AW];
      wr_data_d  = head[DW-1:0];
      wren1_d    = head[EW-1];
      wren2_d    = ~head[EW-1];
      grant_id_d = gnt;
      rr_d       = (gnt == 3'(N_REQ-1)) ? 3'd0 : gnt + 3'd1;
    end
  end

  // Storage carries no reset: occupancy counters alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q       <= '0;
      ovf_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wren1_q    <= 1'b0;
      wren2_q    <= 1'b0;
      grant_id_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      ovf_q      <= ovf_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wren1_q    <= wren1_d;
      wren2_q    <= wren2_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wren1    = wren1_q;
  assign wren2    = wren2_q;
  assign grant_id = grant_id_q;
  assign ovf      = ovf_q;
  assign busy     = (|nonempty) | wren1_q | wren2_q;

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// Randomized and directed bench for orb_wr_arbiter against a queue-based reference model.
module tb_orb_wr_arbiter;

  localparam int N  = 5;
  localparam int AW = 11;
  localparam int DW = 12;
  localparam int D  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            sw;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wren1, wren2;
  logic [2:0]      grant_id;
  logic [N-1:0]    ovf;
  logic            ovf_clr;
  logic            busy;

  int n_chk = 0;
  int n_bad = 0;

  orb_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .sw(sw), .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data), .wr_addr(wr_addr), .wr_data(wr_data), .wren1(wren1),
    .wren2(wren2), .grant_id(grant_id), .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          tag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq [N][$];
  int            m_rr;
  logic [N-1:0]  m_ovf;
  logic          e_w1, e_w2;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            e_gid;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr = 0; m_ovf = '0;
    e_w1 = 1'b0; e_w2 = 1'b0; e_addr = '0; e_data = '0; e_gid = 0;
  endtask

  // One clock edge of the arbiter's documented behaviour, using the inputs as they stand.
  task automatic model_step();
    int   g;
    ent_t e;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
    end
    if (g >= 0) begin
      e      = mq[g].pop_front();
      e_w1   = e.tag;
      e_w2   = !e.tag;
      e_addr = e.addr;
      e_data = e.data;
      e_gid  = g;
      m_rr   = (g + 1) % N;
    end else begin
      e_w1 = 1'b0;
      e_w2 = 1'b0;
    end
    if (ovf_clr) m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      if (req_we[i]) begin
        if (mq[i].size() < D) mq[i].push_back({sw, req_addr[i*AW +: AW], req_data[i*DW +: DW]});
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic pend;
    pend = 1'b0;
    for (int i = 0; i < N; i++) if (mq[i].size() > 0) pend = 1'b1;
    check_val("wren1", wren1, e_w1);
    check_val("wren2", wren2, e_w2);
    check_val("wr_addr", wr_addr, e_addr);
    check_val("wr_data", wr_data, e_data);
    if (e_w1 || e_w2) check_val("grant_id", grant_id, e_gid);
    check_val("ovf", ovf, m_ovf);
    check_val("busy", busy, pend | e_w1 | e_w2);
    check_val("excl", wren1 & wren2, 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    req_we  = '0;
    ovf_clr = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]           = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_we = '0; ovf_clr = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_zero(input string pfx);
    check_val({pfx, "_wren1"}, wren1, 0);
    check_val({pfx, "_wren2"}, wren2, 0);
    check_val({pfx, "_addr"}, wr_addr, 0);
    check_val({pfx, "_data"}, wr_data, 0);
    check_val({pfx, "_gid"}, grant_id, 0);
    check_val({pfx, "_ovf"}, ovf, 0);
    check_val({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    int req0_writes;
    int seen_bad;

    // Reset held with every strobe active
    rst = 1'b0; sw = 1'b0; ovf_clr = 1'b0;
    req_we = '1;
    req_addr = {N{11'h5A5}};
    req_data = {N{12'hC3C}};
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst");
    req_we = '0;
    rst = 1'b1;
    repeat (3) tick();

    // Single write
    sw = 1'b1;
    set_req(2, 11'h1DF, 12'hABC);
    tick();
    tick();
    check_val("single_w1", wren1, 1);
    check_val("single_w2", wren2, 0);
    check_val("single_addr", wr_addr, 11'h1DF);
    check_val("single_data", wr_data, 12'hABC);
    check_val("single_gid", grant_id, 2);
    tick();

    // Contention: all five on one edge
    do_reset();
    sw = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 11'(i * 16 + 3), 12'(i * 100 + 5));
    tick();
    for (int k = 0; k < N; k++) begin
      tick();
      check_val("cont_gid", grant_id, k);
      check_val("cont_w2", wren2, 1);
    end
    check_val("cont_ovf", ovf, 0);
    tick();

    // Overflow on requester 0
    do_reset();
    sw = 1'($urandom_range(0, 1));
    for (int i = 1; i < N; i++) set_req(i, 11'(i), 12'(i));
    tick();
    set_req(0, 11'h010, 12'h111);
    for (int i = 1; i < N; i++) set_req(i, 11'(i + 8), 12'(i + 8));
    tick();
    set_req(0, 11'h020, 12'h222);
    for (int i = 1; i < N; i++) set_req(i, 11'(i + 16), 12'(i + 16));
    tick();
    set_req(0, 11'h030, 12'h333);
    tick();
    check_val("ovf0_set", ovf[0], 1);
    req0_writes = 0;
    seen_bad = 0;
    for (int t = 0; t < 40 && busy; t++) begin
      tick();
      if ((wren1 | wren2) && grant_id == 3'd0) begin
        req0_writes++;
        if (wr_data == 12'h333) seen_bad = 1;
      end
    end
    check_val("ovf_drain", busy, 0);
    check_val("ovf_req0_n", req0_writes, 2);
    check_val("ovf_dropped", seen_bad, 0);
    ovf_clr = 1'b1;
    tick();
    check_val("ovf_clr", ovf, 0);

    // Bank swap while words are pending
    do_reset();
    sw = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 11'(i + 40), 12'(i + 400));
    tick();
    sw = 1'b1;
    set_req(4, 11'h7FF, 12'hFFF);
    tick();
    check_val("swap_first_w2", wren2, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("swap_w1", wren1, k == 3);
      check_val("swap_w2", wren2, k != 3);
    end

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) sw = ~sw;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 35) set_req(i, 11'($urandom), 12'($urandom));
      end
      ovf_clr = ($urandom_range(0, 19) == 0);
      tick();
    end

    // Asynchronous reset while busy
    for (int i = 0; i < N; i++) set_req(i, 11'($urandom), 12'($urandom));
    tick();
    tick();
    check_val("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("arst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) tick();
    check_val("arst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
